// File: rtl/mips_multicycle_seq_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_seq_if
//
// Bundles the signals between the multicycle sequencer and the MIPS datapath
// (instruction register, ALU, register file, unified memory).
//
// Memory handshake: the sequencer raises mem_read or mem_write and keeps
// the request (including iord) stable while mem_ready is low.  The access
// completes in the cycle where a request is active and mem_ready is high.
// mem_ready is ignored whenever no request is active.
//
// master : the sequencer (drives strobes/selects/status, reads IR opcode,
//          ALU zero flag and mem_ready)
// slave  : the datapath / memory side
// ---------------------------------------------------------------------------
interface mips_multicycle_seq_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_sel, alu_src_b, alu_op,
               state, instr_done, illegal, mem_timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_sel, alu_src_b, alu_op,
               state, instr_done, illegal, mem_timeout
    );
endinterface

// File: rtl/mips_multicycle_seq.sv
// ---------------------------------------------------------------------------
// mips_multicycle_seq
//
// Multicycle sequencing controller for the basic MIPS core.  Steps one
// instruction at a time through FETCH / DECODE / EXEC / MEM / WB and issues
// Moore-decoded control strobes for the shared ALU, register file and
// single-port memory.  Stalls in FETCH and MEM until mem_ready.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset; forces all write/read strobes low
//   bus    - mips_multicycle_seq_if.master (opcode/zero/mem_ready in,
//            control strobes, selects, alu_op, state, instr_done, illegal,
//            mem_timeout out)
//
// Parameter:
//   MEM_WAIT_MAX - consecutive stalled cycles in FETCH or MEM after which the
//                  sticky mem_timeout flag is set (4-bit stall counter)
//
// Optional feature macro:
//   MIPS_SEQ_JAL_EN - when defined, opcode 111001 is decoded as JAL; when
//                     undefined it is illegal and the $31 / PC write-back
//                     selects are never driven.
//
// ALU operation codes (ALUop_*) are kept local so the file stands alone;
// they must match the datapath's ALU decoder.
// ---------------------------------------------------------------------------
module mips_multicycle_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_multicycle_seq_if.master   bus
);
    localparam logic [2:0] ALUop_ADD   = 3'b000;
    localparam logic [2:0] ALUop_SUB   = 3'b001;
    localparam logic [2:0] ALUop_AND   = 3'b010;
    localparam logic [2:0] ALUop_OR    = 3'b011;
    localparam logic [2:0] ALUop_LESS  = 3'b100;
    localparam logic [2:0] ALUop_RTYPE = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
`ifdef MIPS_SEQ_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b111001;
`endif

    localparam logic [4:0] WAIT_LIMIT = 5'(MEM_WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic [3:0] stall_cnt;
    logic       done_q, illegal_q, timeout_q;
    logic       retire_d, illegal_d, stalled;
    logic [4:0] stall_nxt;

    logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    // Opcodes that continue from DECODE into EXEC.
    function automatic logic needs_exec(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: needs_exec = 1'b1;
            default:                      needs_exec = 1'b0;
        endcase
    endfunction

    // Next state and Moore outputs.  DECODE looks at the live IR opcode;
    // EXEC/MEM/WB use op_q so later IR changes cannot disturb them.
    always_comb begin
        state_d       = state_q;
        retire_d      = 1'b0;
        illegal_d     = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        bus.iord      = 1'b0;
        bus.pc_src    = 2'd0;
        bus.reg_dst   = 2'd0;
        bus.wb_sel    = 2'd0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 3'd0;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_J: begin
                        pc_write_c = 1'b1;
                        bus.pc_src = 2'd2;
                        state_d    = S_FETCH;
                        retire_d   = 1'b1;
                    end
`ifdef MIPS_SEQ_JAL_EN
                    OP_JAL: begin
                        pc_write_c  = 1'b1;
                        bus.pc_src  = 2'd2;
                        reg_write_c = 1'b1;
                        bus.reg_dst = 2'd2;
                        bus.wb_sel  = 2'd2;
                        state_d     = S_FETCH;
                        retire_d    = 1'b1;
                    end
`endif
                    default: begin
                        if (needs_exec(bus.opcode)) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op_q)
                    OP_RTYPE: bus.alu_op = ALUop_RTYPE;
                    OP_ADDI: begin bus.alu_op = ALUop_ADD;  bus.alu_src_b = 1'b1; end
                    OP_SUBI: begin bus.alu_op = ALUop_SUB;  bus.alu_src_b = 1'b1; end
                    OP_ANDI: begin bus.alu_op = ALUop_AND;  bus.alu_src_b = 1'b1; end
                    OP_ORI:  begin bus.alu_op = ALUop_OR;   bus.alu_src_b = 1'b1; end
                    OP_SLTI: begin bus.alu_op = ALUop_LESS; bus.alu_src_b = 1'b1; end
                    OP_LW, OP_SW: begin
                        bus.alu_op    = ALUop_ADD;
                        bus.alu_src_b = 1'b1;
                        state_d       = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        bus.alu_op = ALUop_SUB;
                        bus.pc_src = 2'd1;
                        // op_q[2] separates BNE (100111) from BEQ (100011).
                        pc_write_c = op_q[2] ? !bus.zero : bus.zero;
                        state_d    = S_FETCH;
                        retire_d   = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                bus.iord    = 1'b1;
                mem_read_c  = (op_q == OP_LW);
                mem_write_c = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                if (op_q == OP_RTYPE) bus.reg_dst = 2'd1;
                if (op_q == OP_LW)    bus.wb_sel  = 2'd1;
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign stalled   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    assign stall_nxt = {1'b0, stall_cnt} + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            stall_cnt <= 4'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= retire_d;
            illegal_q <= illegal_d;
            if (state_q == S_DECODE) op_q <= bus.opcode;
            // Counter restarts on each fresh entry into a waiting state and
            // saturates rather than wrapping during very long stalls.
            if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
                stall_cnt <= 4'd0;
            end else if (stalled && (stall_cnt != 4'hF)) begin
                stall_cnt <= stall_nxt[3:0];
            end
            if (stalled && (stall_nxt >= WAIT_LIMIT)) timeout_q <= 1'b1;
        end
    end

    // Strobes are gated by reset directly so they fall without waiting for
    // the asynchronous state reset to propagate through the decode.
    assign bus.mem_read    = mem_read_c  && !reset;
    assign bus.mem_write   = mem_write_c && !reset;
    assign bus.ir_write    = ir_write_c  && !reset;
    assign bus.pc_write    = pc_write_c  && !reset;
    assign bus.reg_write   = reg_write_c && !reset;
    assign bus.state       = state_q;
    assign bus.instr_done  = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_mips_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_seq
//
// Directed bench for mips_multicycle_seq: a table of per-instruction records
// (opcode, zero, expected per-cycle state/strobe masks and selects) plus
// hand-written sequences for stalls, timeout, JAL and reset mid-instruction.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_seq;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_LESS  = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        int          n;
        logic [14:0] st;     // state of cycle c at [3c +: 3]
        logic [4:0]  regw;   // bit c = reg_write expected in cycle c
        logic [4:0]  pcw;
        logic [4:0]  mrd;
        logic [4:0]  mwr;
        logic [2:0]  alu;    // EXEC cycle
        logic        srcb;   // EXEC cycle
        logic [1:0]  dst;    // cycles with reg_write
        logic [1:0]  wbs;    // cycles with reg_write
        logic [1:0]  psrc;   // non-FETCH cycles with pc_write
        logic        ill;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    mips_multicycle_seq_if bus();

    mips_multicycle_seq #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [14:0] st5(input logic [2:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic z, input int n,
                                input logic [14:0] st, input logic [4:0] regw, pcw, mrd, mwr,
                                input logic [2:0] alu, input logic srcb,
                                input logic [1:0] dst, wbs, psrc, input logic ill, done);
        vec_t v;
        v.op = op; v.z = z; v.n = n; v.st = st; v.regw = regw; v.pcw = pcw;
        v.mrd = mrd; v.mwr = mwr; v.alu = alu; v.srcb = srcb; v.dst = dst;
        v.wbs = wbs; v.psrc = psrc; v.ill = ill; v.done = done;
        return v;
    endfunction

    initial begin
        logic [2:0] lw_st[7];
        logic       lw_rdy[7];
        vec_t       v;

        // R-type first: matches the post-reset sequence 0,1,2,4,0.
        vecs.push_back(mk(6'b000000, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_RTYPE, 0, 2'd1, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b000010, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_ADD,   1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b000011, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_SUB,   1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b000100, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_AND,   1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b000101, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_OR,    1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b000111, 0, 4, st5(0,1,2,4,0), 5'b01000, 5'b00001, 5'b00001, 5'b0, ALU_LESS,  1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b001000, 0, 5, st5(0,1,2,3,4), 5'b10000, 5'b00001, 5'b01001, 5'b0, ALU_ADD,   1, 2'd0, 2'd1, 2'd0, 0, 1));
        vecs.push_back(mk(6'b010000, 0, 4, st5(0,1,2,3,0), 5'b00000, 5'b00001, 5'b00001, 5'b01000, ALU_ADD, 1, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(6'b100011, 1, 3, st5(0,1,2,0,0), 5'b00000, 5'b00101, 5'b00001, 5'b0, ALU_SUB,   0, 2'd0, 2'd0, 2'd1, 0, 1));
        vecs.push_back(mk(6'b100011, 0, 3, st5(0,1,2,0,0), 5'b00000, 5'b00001, 5'b00001, 5'b0, ALU_SUB,   0, 2'd0, 2'd0, 2'd1, 0, 1));
        vecs.push_back(mk(6'b100111, 1, 3, st5(0,1,2,0,0), 5'b00000, 5'b00001, 5'b00001, 5'b0, ALU_SUB,   0, 2'd0, 2'd0, 2'd1, 0, 1));
        vecs.push_back(mk(6'b100111, 0, 3, st5(0,1,2,0,0), 5'b00000, 5'b00101, 5'b00001, 5'b0, ALU_SUB,   0, 2'd0, 2'd0, 2'd1, 0, 1));
        vecs.push_back(mk(6'b111000, 0, 2, st5(0,1,0,0,0), 5'b00000, 5'b00011, 5'b00001, 5'b0, 3'd0,      0, 2'd0, 2'd0, 2'd2, 0, 1));
        vecs.push_back(mk(6'b110000, 0, 2, st5(0,1,0,0,0), 5'b00000, 5'b00001, 5'b00001, 5'b0, 3'd0,      0, 2'd0, 2'd0, 2'd0, 1, 0));
        vecs.push_back(mk(6'b000110, 0, 2, st5(0,1,0,0,0), 5'b00000, 5'b00001, 5'b00001, 5'b0, 3'd0,      0, 2'd0, 2'd0, 2'd0, 1, 0));
`ifdef MIPS_SEQ_JAL_EN
        vecs.push_back(mk(6'b111001, 0, 2, st5(0,1,0,0,0), 5'b00010, 5'b00011, 5'b00001, 5'b0, 3'd0,      0, 2'd2, 2'd2, 2'd2, 0, 1));
`else
        vecs.push_back(mk(6'b111001, 0, 2, st5(0,1,0,0,0), 5'b00000, 5'b00001, 5'b00001, 5'b0, 3'd0,      0, 2'd0, 2'd0, 2'd0, 1, 0));
`endif

        // ---- reset: 3 cycles, mem_ready high, opcode R-type ----
        reset = 1'b1;
        bus.opcode = 6'b000000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_strobes", 32'({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write}), 32'd0);
            chk("reset_state", 32'(bus.state), 32'd0);
            chk("reset_flags", 32'({bus.instr_done, bus.illegal, bus.mem_timeout}), 32'd0);
        end
        reset = 1'b0;
        #1;

        // ---- table-driven instructions with mem_ready tied high ----
        foreach (vecs[i]) begin
            v = vecs[i];
            bus.opcode = v.op;
            bus.zero = v.z;
            #1;
            for (int c = 0; c < v.n; c++) begin
                chk($sformatf("v%0d_c%0d_state", i, c), 32'(bus.state), 32'(v.st[3*c +: 3]));
                chk($sformatf("v%0d_c%0d_reg_write", i, c), 32'(bus.reg_write), 32'(v.regw[c]));
                chk($sformatf("v%0d_c%0d_pc_write", i, c), 32'(bus.pc_write), 32'(v.pcw[c]));
                chk($sformatf("v%0d_c%0d_mem_read", i, c), 32'(bus.mem_read), 32'(v.mrd[c]));
                chk($sformatf("v%0d_c%0d_mem_write", i, c), 32'(bus.mem_write), 32'(v.mwr[c]));
                chk($sformatf("v%0d_c%0d_ir_write", i, c), 32'(bus.ir_write), 32'(c == 0));
                if (c == 2) begin
                    chk($sformatf("v%0d_alu_op", i), 32'(bus.alu_op), 32'(v.alu));
                    chk($sformatf("v%0d_alu_src_b", i), 32'(bus.alu_src_b), 32'(v.srcb));
                end
                if (v.regw[c]) begin
                    chk($sformatf("v%0d_reg_dst", i), 32'(bus.reg_dst), 32'(v.dst));
                    chk($sformatf("v%0d_wb_sel", i), 32'(bus.wb_sel), 32'(v.wbs));
                end
                if (v.pcw[c]) begin
                    chk($sformatf("v%0d_c%0d_pc_src", i, c), 32'(bus.pc_src), (c == 0) ? 32'd0 : 32'(v.psrc));
                end
                if (c > 0) chk($sformatf("v%0d_c%0d_done_low", i, c), 32'(bus.instr_done), 32'd0);
                step();
            end
            chk($sformatf("v%0d_end_state", i), 32'(bus.state), 32'd0);
            chk($sformatf("v%0d_instr_done", i), 32'(bus.instr_done), 32'(v.done));
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal), 32'(v.ill));
        end

        // ---- LW with 2 stall cycles in MEM; IR changes after DECODE ----
        lw_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 6'b001000;
        for (int c = 0; c < 7; c++) begin
            bus.mem_ready = lw_rdy[c];
            if (c == 2) bus.opcode = 6'b000000;
            #1;
            chk($sformatf("lw_stall_c%0d_state", c), 32'(bus.state), 32'(lw_st[c]));
            if (lw_st[c] == 3'd3) begin
                chk($sformatf("lw_stall_c%0d_mem_read", c), 32'(bus.mem_read), 32'd1);
                chk($sformatf("lw_stall_c%0d_iord", c), 32'(bus.iord), 32'd1);
                chk($sformatf("lw_stall_c%0d_mem_write", c), 32'(bus.mem_write), 32'd0);
            end
            if (c == 6) begin
                chk("lw_stall_reg_write", 32'(bus.reg_write), 32'd1);
                chk("lw_stall_wb_sel", 32'(bus.wb_sel), 32'd1);
            end
            step();
        end
        chk("lw_stall_end_state", 32'(bus.state), 32'd0);
        chk("lw_stall_done", 32'(bus.instr_done), 32'd1);

        // ---- 16 stalled cycles in FETCH -> sticky mem_timeout ----
        bus.mem_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 14) chk("timeout_before_limit", 32'(bus.mem_timeout), 32'd0);
            if (k == 16) begin
                chk("timeout_set", 32'(bus.mem_timeout), 32'd1);
                chk("timeout_still_fetch", 32'(bus.state), 32'd0);
                chk("timeout_mem_read_held", 32'(bus.mem_read), 32'd1);
                chk("timeout_no_ir_write", 32'(bus.ir_write), 32'd0);
            end
        end

        // ---- J after the timeout: flag stays, jump target selected ----
        bus.opcode = 6'b111000;
        bus.mem_ready = 1'b1;
        step();
        chk("j_decode_pc_write", 32'(bus.pc_write), 32'd1);
        chk("j_decode_pc_src", 32'(bus.pc_src), 32'd2);
        step();
        chk("j_done", 32'(bus.instr_done), 32'd1);
        chk("timeout_sticky", 32'(bus.mem_timeout), 32'd1);

        // ---- JAL decode selects ----
        bus.opcode = 6'b111001;
        step();
        chk("jal_state", 32'(bus.state), 32'd1);
`ifdef MIPS_SEQ_JAL_EN
        chk("jal_reg_write", 32'(bus.reg_write), 32'd1);
        chk("jal_reg_dst", 32'(bus.reg_dst), 32'd2);
        chk("jal_wb_sel", 32'(bus.wb_sel), 32'd2);
        chk("jal_pc_src", 32'(bus.pc_src), 32'd2);
        step();
        chk("jal_done", 32'(bus.instr_done), 32'd1);
`else
        chk("jal_off_reg_write", 32'(bus.reg_write), 32'd0);
        chk("jal_off_reg_dst", 32'(bus.reg_dst), 32'd0);
        chk("jal_off_wb_sel", 32'(bus.wb_sel), 32'd0);
        step();
        chk("jal_off_illegal", 32'(bus.illegal), 32'd1);
        chk("jal_off_done", 32'(bus.instr_done), 32'd0);
`endif

        // ---- reset asserted in the middle of an SW memory stall ----
        bus.opcode = 6'b010000;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        chk("sw_mem_state", 32'(bus.state), 32'd3);
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        chk("sw_mem_iord", 32'(bus.iord), 32'd1);
        step();
        chk("sw_mem_write_held", 32'(bus.mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("sw_reset_mem_write", 32'(bus.mem_write), 32'd0);
        chk("sw_reset_state", 32'(bus.state), 32'd0);
        chk("sw_reset_timeout_clear", 32'(bus.mem_timeout), 32'd0);
        step();
        chk("sw_reset_strobes", 32'({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write}), 32'd0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("restart_state", 32'(bus.state), 32'd0);
        chk("restart_mem_read", 32'(bus.mem_read), 32'd1);
        chk("restart_done", 32'(bus.instr_done), 32'd0);
        step();
        chk("restart_decode", 32'(bus.state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_seq.md
# mips_multicycle_seq

Multicycle sequencing controller for the basic MIPS core. It steps a single shared ALU, register file and single-port unified memory through the FETCH / DECODE / EXEC / MEM / WB phases, one instruction at a time. It issues per-state control strobes, sits between the instruction register and the datapath muxes, and stalls on a memory-ready handshake.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive stall cycles in one memory state before `mem_timeout` is asserted (4-bit counter).
- `clk` input 1: clock; all state updates occur on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in EXEC for branches.
- `mem_ready` input 1: memory access completes this cycle.
- `mem_read`, `mem_write` output 1: memory strobes.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load the IR.
- `pc_write` output 1: load the PC.
- `pc_src` output 2: PC source; 0 = PC+4, 1 = branch target, 2 = jump target.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 2: write register select; 0 = rt, 1 = rd, 2 = $31.
- `wb_sel` output 2: write-back data select; 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_b` output 1: ALU operand B; 0 = rt, 1 = sign-extended immediate.
- `alu_op` output 3: ALU operation, using the `ALUop_*` codes from `mips_defines.vh`.
- `state` output 3: current state, for debug.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `illegal` output 1: one-cycle pulse when an opcode is undecodable.
- `mem_timeout` output 1: sticky flag, cleared only by `reset`.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable; if entered, the next state is FETCH.
- Outputs are Moore-decoded from the state and the registered opcode. Any output not listed for a state is 0.
- **FETCH:** `mem_read=1`, `iord=0`. The block holds in FETCH while `mem_ready=0`. In the cycle with `mem_ready=1` it also asserts `ir_write=1` and `pc_write=1` (`pc_src=0`), then moves to DECODE.
- **DECODE**, by opcode:
  - J (111000): `pc_write=1`, `pc_src=2`; go to FETCH and retire.
  - JAL (111001): as J, plus `reg_write=1`, `reg_dst=2`, `wb_sel=2`; go to FETCH and retire.
  - Any opcode not in the lists below: pulse `illegal`, go to FETCH, no retire.
  - All other decoded opcodes: go to EXEC.
- **EXEC**, by opcode:
  - R-type (000000): `alu_op=ALUop_RTYPE`, `alu_src_b=0`; go to WB.
  - ADDI 000010 / SUBI 000011 / ANDI 000100 / ORI 000101 / SLTI 000111: `alu_op` = ADD / SUB / AND / OR / LESS respectively, `alu_src_b=1`; go to WB.
  - LW 001000 / SW 010000: `alu_op=ALUop_ADD`, `alu_src_b=1`; go to MEM.
  - BEQ 100011 / BNE 100111: `alu_op=ALUop_SUB`, `alu_src_b=0`, `pc_src=1`. `pc_write` = `zero` for BEQ, `!zero` for BNE. Go to FETCH and retire.
- **MEM:** `iord=1`; `mem_read=1` for LW, `mem_write=1` for SW. The block holds while `mem_ready=0`. On `mem_ready=1`, LW goes to WB; SW goes to FETCH and retires.
- **WB:** `reg_write=1`.
  - R-type: `reg_dst=1`, `wb_sel=0`.
  - Immediate ops: `reg_dst=0`, `wb_sel=0`.
  - LW: `reg_dst=0`, `wb_sel=1`.
  - Next state FETCH; retire.
- **Retire:** `instr_done` is registered. It is high for exactly the first cycle of the FETCH that follows a retiring state.
- **Stall counter:** 4 bits; clears on entry to FETCH or MEM and increments each stalled cycle. When it reaches `MEM_WAIT_MAX`, `mem_timeout` is set. The stall itself continues.

## Timing
- Reset values: `state`=FETCH; `instr_done`=0, `illegal`=0, `mem_timeout`=0, stall counter 0.
- While `reset` is high, all strobes are forced to 0: `mem_read`, `mem_write`, `ir_write`, `pc_write`, `reg_write`.
- Reset asserted in any state aborts the instruction: no further writes, and the block restarts in FETCH after deassertion.
- Cycles per instruction with `mem_ready` tied to 1:
  - J, JAL, illegal: 2.
  - Branch: 3.
  - R-type, immediate ops, SW: 4.
  - LW: 5.
- Each cycle that `mem_ready` is low in FETCH or MEM adds one cycle.
- `mem_ready` high outside FETCH or MEM is ignored.
- The opcode is registered on the cycle the block leaves DECODE. Opcode changes after DECODE do not affect EXEC, MEM or WB.

## Configuration
- `MIPS_SEQ_JAL_EN` defined: JAL is decoded as described in Operation.
- `MIPS_SEQ_JAL_EN` undefined: 111001 is treated as illegal, and `reg_dst=2` and `wb_sel=2` are never driven.

## Test plan
- Reset held for 3 cycles, then released with `mem_ready=1` and opcode 000000 → no strobe during reset; `state` sequence 0,1,2,4,0; `reg_write` high only in the WB cycle; `instr_done` pulses once.
- LW with `mem_ready` low for 2 cycles in MEM → `state` sequence 0,1,2,3,3,3,4,0; `mem_read` and `iord` stable through the stall; 7 cycles total.
- BEQ with `zero=1`, then BNE with `zero=1` → first has `pc_write=1` with `pc_src=1` in EXEC; second has `pc_write=0`; each takes 3 cycles.
- Opcode 110000 → `illegal` pulses in the cycle after DECODE; no `reg_write` or `mem_write`; `instr_done` stays 0.
- JAL with `MIPS_SEQ_JAL_EN` defined → DECODE shows `reg_write=1`, `reg_dst=2`, `wb_sel=2`, `pc_src=2`. Without the macro → `illegal` pulses.
- `mem_ready` held low for 16 cycles in FETCH → `mem_timeout` rises and stays set until `reset`; `reset` asserted mid-MEM of an SW → `mem_write` drops asynchronously and `state`=0.
